// File: rtl/touch_pkg.sv
// Shared encodings for the touch gesture controller: LED mode and gesture FSM states.
package touch_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/touch_debounce.sv
// Two-flop synchronizer for the touch pad followed by a consecutive-cycle debouncer.
module touch_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic touch_key,
  output logic deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Any cycle where the synchronized level agrees with deb restarts the run.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= touch_key;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt >= CNT_TC) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/touch_gesture_ctrl.sv
// Touch gesture controller: classifies debounced presses into tap / double tap / long press
// and drives an LED through OFF, ON and BLINK modes.
//
// state  | meaning
// IDLE   | waiting for a press
// PRESS1 | first press held, timing toward long press
// WAIT2  | released, timing the gap for a second press
// PRESS2 | second press held, timing toward long press
// HELD   | long press already reported, waiting for release
module touch_gesture_ctrl
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC     = 50000000,
  parameter int DTAP_CYC     = 15000000,
  parameter int BLINK_CYC    = 12500000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       touch_key,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       tap_pulse,
  output logic       dtap_pulse,
  output logic       long_pulse
);

  localparam int HOLD_MAX = max2(LONG_CYC, DTAP_CYC);
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;
  localparam int BLINK_W  = $clog2(BLINK_CYC) + 1;

  localparam logic [HOLD_W-1:0]  LONG_TC  = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0]  DTAP_TC  = HOLD_W'(DTAP_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_SAT = HOLD_W'(HOLD_MAX);
  localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_CYC - 1);

  logic               deb;
  state_t             state;
  state_t             state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  mode_t              mode_q;
  mode_t              mode_nxt;
  logic               blink_led;
  logic [BLINK_W-1:0] blink_cnt;
  logic               tap_set;
  logic               dtap_set;
  logic               long_set;

  touch_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .touch_key(touch_key),
    .deb      (deb)
  );

  // Timer thresholds are tested before deb so a coincident edge is seen in the next state.
  always_comb begin
    state_nxt = state;
    tap_set   = 1'b0;
    dtap_set  = 1'b0;
    long_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (deb) state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (hold_cnt == LONG_TC) begin
          long_set  = 1'b1;
          state_nxt = ST_HELD;
        end else if (!deb) begin
          state_nxt = ST_WAIT2;
        end
      end
      ST_WAIT2: begin
        if (hold_cnt == DTAP_TC) begin
          tap_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (deb) begin
          state_nxt = ST_PRESS2;
        end
      end
      ST_PRESS2: begin
        if (hold_cnt == LONG_TC) begin
          long_set  = 1'b1;
          state_nxt = ST_HELD;
        end else if (!deb) begin
          dtap_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!deb) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_nxt = mode_q;
    if (tap_set) begin
      mode_nxt = (mode_q == MODE_OFF) ? MODE_ON : MODE_OFF;
    end else if (dtap_set) begin
      mode_nxt = MODE_BLINK;
    end else if (long_set) begin
      mode_nxt = MODE_OFF;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      mode_q     <= MODE_OFF;
      tap_pulse  <= 1'b0;
      dtap_pulse <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      mode_q     <= mode_nxt;
      tap_pulse  <= tap_set;
      dtap_pulse <= dtap_set;
      long_pulse <= long_set;
      if (state_nxt != state) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_SAT) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Every double tap, including one while already blinking, restarts the phase lit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      blink_led <= 1'b0;
      blink_cnt <= '0;
    end else if (dtap_set) begin
      blink_led <= 1'b1;
      blink_cnt <= '0;
    end else if (mode_q == MODE_BLINK) begin
      if (blink_cnt >= BLINK_TC) begin
        blink_led <= ~blink_led;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end else begin
      blink_cnt <= '0;
    end
  end

  assign led_out = (mode_q == MODE_ON) || ((mode_q == MODE_BLINK) && blink_led);
  assign mode    = mode_q;

endmodule

// File: tb/tb_touch_gesture_ctrl.sv
// Directed bench for touch_gesture_ctrl: table of touch waveforms with hand-computed results,
// plus hand sequences for reset mid-gesture and blink phase restart.
module tb_touch_gesture_ctrl;
  import touch_pkg::*;

  localparam int RUN = 150;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       touch_key = 1'b0;
  logic       led_out;
  logic [1:0] mode;
  logic       tap_pulse;
  logic       dtap_pulse;
  logic       long_pulse;

  always #5 sys_clk = ~sys_clk;

  touch_gesture_ctrl #(
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (50),
    .DTAP_CYC    (20),
    .BLINK_CYC   (10)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .touch_key (touch_key),
    .led_out   (led_out),
    .mode      (mode),
    .tap_pulse (tap_pulse),
    .dtap_pulse(dtap_pulse),
    .long_pulse(long_pulse)
  );

  // s0..s6: alternating high/low touch durations starting high; first = cycle of first pulse.
  typedef struct packed {
    int         s0, s1, s2, s3, s4, s5, s6;
    int         n_tap, n_dtap, n_long, first;
    logic [1:0] mode;
    logic       led;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   n_tap, n_dtap, n_long, first, multi;
  logic led_hist [RUN];
  vec_t tab [13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int s0, s1, s2, s3, s4, s5, s6,
                              input int nt, nd, nl, fc, input int md, input int ld);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.s4 = s4; v.s5 = s5; v.s6 = s6;
    v.n_tap = nt; v.n_dtap = nd; v.n_long = nl; v.first = fc;
    v.mode = 2'(md);
    v.led  = 1'(ld);
    return v;
  endfunction

  function automatic logic lvl(input vec_t v, input int c);
    int b1 = v.s0;
    int b2 = b1 + v.s1;
    int b3 = b2 + v.s2;
    int b4 = b3 + v.s3;
    int b5 = b4 + v.s4;
    int b6 = b5 + v.s5;
    int b7 = b6 + v.s6;
    return (c < b1) || (c >= b2 && c < b3) || (c >= b4 && c < b5) || (c >= b6 && c < b7);
  endfunction

  task automatic do_reset();
    sys_rst   = 1'b1;
    touch_key = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Cycle c: touch driven before posedge c, outputs sampled on the following negedge.
  task automatic run_vec(input vec_t v);
    int p;
    do_reset();
    n_tap = 0; n_dtap = 0; n_long = 0; first = -1; multi = 0;
    for (int c = 0; c < RUN; c++) begin
      touch_key = lvl(v, c);
      @(posedge sys_clk);
      @(negedge sys_clk);
      p = int'(tap_pulse) + int'(dtap_pulse) + int'(long_pulse);
      if (p > 1) multi++;
      if (p > 0 && first < 0) first = c;
      n_tap  += int'(tap_pulse);
      n_dtap += int'(dtap_pulse);
      n_long += int'(long_pulse);
      led_hist[c] = led_out;
    end
    touch_key = 1'b0;
  endtask

  initial begin
    int e;
    tab[0]  = mk(10, 0, 0, 0, 0, 0, 0,   1, 0, 0, 36,  1, 1);  // single tap
    tab[1]  = mk(10, 8, 10, 0, 0, 0, 0,  0, 1, 0, 34,  2, 0);  // double tap
    tab[2]  = mk(10, 8, 60, 0, 0, 0, 0,  0, 0, 1, 74,  0, 0);  // second press long
    tab[3]  = mk(80, 0, 0, 0, 0, 0, 0,   0, 0, 1, 56,  0, 0);  // long from OFF
    tab[4]  = mk(49, 0, 0, 0, 0, 0, 0,   1, 0, 0, 75,  1, 1);  // release one cycle before long
    tab[5]  = mk(50, 0, 0, 0, 0, 0, 0,   0, 0, 1, 56,  0, 0);  // release coincident with long
    tab[6]  = mk(4, 0, 0, 0, 0, 0, 0,    1, 0, 0, 30,  1, 1);  // shortest accepted press
    tab[7]  = mk(3, 0, 0, 0, 0, 0, 0,    0, 0, 0, -1,  0, 0);  // just too short
    tab[8]  = mk(3, 3, 3, 3, 3, 3, 0,    0, 0, 0, -1,  0, 0);  // glitch train
    tab[9]  = mk(10, 19, 10, 0, 0, 0, 0, 0, 1, 0, 45,  2, 1);  // longest gap for double tap
    tab[10] = mk(10, 20, 10, 0, 0, 0, 0, 2, 0, 0, 36,  0, 0);  // gap hits limit: two taps
    tab[11] = mk(10, 8, 10, 40, 10, 0, 0, 1, 1, 0, 34, 0, 0);  // tap from BLINK -> OFF
    tab[12] = mk(10, 40, 80, 0, 0, 0, 0, 1, 0, 1, 36,  0, 0);  // long from ON

    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst led", int'(led_out), 0);
    chk("rst mode", int'(mode), 0);
    chk("rst pulses", int'({tap_pulse, dtap_pulse, long_pulse}), 0);
    chk("rst state", int'(dut.state), int'(ST_IDLE));

    for (int i = 0; i < 13; i++) begin
      run_vec(tab[i]);
      chk($sformatf("v%0d tap_cnt", i), n_tap, tab[i].n_tap);
      chk($sformatf("v%0d dtap_cnt", i), n_dtap, tab[i].n_dtap);
      chk($sformatf("v%0d long_cnt", i), n_long, tab[i].n_long);
      chk($sformatf("v%0d first_pulse", i), first, tab[i].first);
      chk($sformatf("v%0d multi_pulse", i), multi, 0);
      chk($sformatf("v%0d mode", i), int'(mode), int'(tab[i].mode));
      chk($sformatf("v%0d led", i), int'(led_out), int'(tab[i].led));
    end

    // Two double taps: dtaps at 34 and 74; the second restarts the blink phase lit.
    run_vec(mk(10, 8, 10, 12, 10, 8, 10, 0, 0, 0, 0, 0, 0));
    chk("reblink dtap_cnt", n_dtap, 2);
    chk("reblink tap_cnt", n_tap, 0);
    for (int c = 0; c < RUN; c++) begin
      e = (c < 34) ? 0 : ((((c - ((c >= 74) ? 74 : 34)) / 10) % 2) == 0) ? 1 : 0;
      chk($sformatf("reblink led c%0d", c), int'(led_hist[c]), e);
    end

    // Reset during WAIT2 (entered at cycle 16; tap would fire at 36).
    do_reset();
    for (int c = 0; c < 25; c++) begin
      touch_key = (c < 10);
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    chk("midrst pre state", int'(dut.state), int'(ST_WAIT2));
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("midrst led", int'(led_out), 0);
    chk("midrst mode", int'(mode), 0);
    chk("midrst pulses", int'({tap_pulse, dtap_pulse, long_pulse}), 0);
    chk("midrst state", int'(dut.state), int'(ST_IDLE));
    chk("midrst deb", int'(dut.deb), 0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    n_tap = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      n_tap += int'(tap_pulse) + int'(dtap_pulse) + int'(long_pulse);
    end
    chk("midrst no pulse", n_tap, 0);
    chk("midrst mode after", int'(mode), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
